// File: rtl/hilo_pkg.sv
// Shared op codes and FSM state encoding for the Hi/Lo multiply/divide sequencer.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIX   = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: shift-add multiply or restoring divide on operand magnitudes,
// followed by a one-cycle sign correction.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic             signed_op,
  input  logic             div_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  // hi_q: upper product half / remainder; lo_q: multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0]   hi_q, lo_q, b_q;
  logic               div_q, neg_main, neg_rem;
  logic [WIDTH:0]     add_sum, shifted, diff;
  logic [2*WIDTH-1:0] prod_neg;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign add_sum  = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
  assign shifted  = {hi_q, lo_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, b_q};
  assign prod_neg = -{hi_q, lo_q};
  assign hi_res   = hi_q;
  assign lo_res   = lo_q;

  always_ff @(posedge clk) begin
    if (load) begin
      hi_q     <= '0;
      lo_q     <= magnitude(a, signed_op);
      b_q      <= magnitude(b, signed_op);
      div_q    <= div_op;
      neg_main <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem  <= signed_op & div_op & a[WIDTH-1];
    end else if (step) begin
      if (div_q) begin
        // A set borrow bit means the trial subtraction failed: restore
        if (!diff[WIDTH]) begin
          hi_q <= diff[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_q <= shifted[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_q <= add_sum[WIDTH:1];
        lo_q <= {add_sum[0], lo_q[WIDTH-1:1]};
      end
    end else if (fix) begin
      if (div_q) begin
        if (neg_main) lo_q <= -lo_q;
        if (neg_rem)  hi_q <= -hi_q;
      end else if (neg_main) begin
        {hi_q, lo_q} <= prod_neg;
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_controller.sv
// Sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO into HiRegister/LoRegister writes and
// stalls the pipeline while an operation is in flight.
module hilo_muldiv_controller
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] rt_value,
  input  logic             mf_request,
  output logic             busy,
  output logic             stall,
  output logic             hi_enable,
  output logic             lo_enable,
  output logic [WIDTH-1:0] hi_pw,
  output logic [WIDTH-1:0] lo_pw,
  output logic             div_by_zero
);

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic             accept, is_div, zero_div, start, dbz, mthi, mtlo, signed_op;
  logic             load, step, fix;
  logic [WIDTH-1:0] hi_res, lo_res;

  // busy is still high in the WRITE cycle, so nothing is accepted until it drops
  assign accept    = (state == ST_IDLE) && !busy && op_valid;
  assign is_div    = (op_code == OP_DIV) || (op_code == OP_DIVU);
  assign zero_div  = is_div && (rt_value == '0);
  assign start     = accept && (op_code <= OP_DIVU) && !zero_div;
  assign dbz       = accept && zero_div;
  assign mthi      = accept && (op_code == OP_MTHI);
  assign mtlo      = accept && (op_code == OP_MTLO);
  assign signed_op = (op_code == OP_MULT) || (op_code == OP_DIV);
  assign stall     = busy & (op_valid | mf_request);

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .load      (load),
    .step      (step),
    .fix       (fix),
    .signed_op (signed_op),
    .div_op    (is_div),
    .a         (rs_value),
    .b         (rt_value),
    .hi_res    (hi_res),
    .lo_res    (lo_res)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (count == CNT_W'(WIDTH - 1)) state_next = ST_FIX;
      end
      ST_FIX: begin
        fix        = 1'b1;
        state_next = ST_WRITE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      busy        <= 1'b0;
      hi_enable   <= 1'b0;
      lo_enable   <= 1'b0;
      div_by_zero <= 1'b0;
      hi_pw       <= '0;
      lo_pw       <= '0;
    end else begin
      state       <= state_next;
      if (load)      count <= '0;
      else if (step) count <= count + 1'b1;
      busy        <= start | dbz | (state != ST_IDLE);
      hi_enable   <= mthi | dbz | (state == ST_WRITE);
      lo_enable   <= mtlo | dbz | (state == ST_WRITE);
      div_by_zero <= dbz;
      // A zero divisor short-circuits straight to the write: hi=dividend, lo=all ones
      if (mthi || dbz)           hi_pw <= rs_value;
      else if (state == ST_WRITE) hi_pw <= hi_res;
      if (mtlo)                  lo_pw <= rs_value;
      else if (dbz)              lo_pw <= '1;
      else if (state == ST_WRITE) lo_pw <= lo_res;
    end
  end

endmodule
